mem_port_arbiter: RTL

- Shares the single cached memory port (RAMTop-style valid/ready request interface) between two requesters: the instruction-fetch port and the load/store data port of the pipeline.
- Fixed priority: data over instruction, with a starvation guard.
- Each transaction is registered, forwarded downstream and held until the memory signals ready; the result is returned to the granted requester one cycle later.

---
 rtl/mem_port_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory request port between instruction fetch and load/store,
// data-first priority with a starvation guard for fetches.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = 4,
  parameter logic [1:0] WIDTH_WORD = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_sign,
  input  logic [1:0]        d_width,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_write,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_sign,
  output logic [1:0]        m_width,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              grant_d,
  output logic              busy
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic pick_i, go, done;
  always_comb begin
    go = i_valid || d_valid;
    pick_i = i_valid && (!d_valid || cnt == CW'(STARVE_LIMIT));
    done = state == BUSY && m_ready;
    state_n = state == IDLE ? (go ? BUSY : IDLE) : state == BUSY ? (m_ready ? DONE : BUSY) : IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_addr <= '0;
      m_write <= 1'b0;
      m_wdata <= '0;
      m_sign <= 1'b0;
      m_width <= WIDTH_WORD;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      grant_d <= 1'b0;
      cnt <= '0;
    end else begin
      i_ready <= done && !grant_d;
      d_ready <= done && grant_d;
      if (state == IDLE && go) begin
        grant_d <= !pick_i;
        m_valid <= 1'b1;
        m_addr <= pick_i ? i_addr : d_addr;
        m_write <= !pick_i && d_write;
        m_wdata <= pick_i ? '0 : d_wdata;
        m_sign <= !pick_i && d_sign;
        m_width <= pick_i ? WIDTH_WORD : d_width;
        // a data grant that bypasses a waiting fetch moves the fetch closer to a forced grant
        cnt <= (!pick_i && i_valid) ? (cnt == CW'(STARVE_LIMIT) ? cnt : cnt + 1'b1) : '0;
      end
      if (done) begin
        m_valid <= 1'b0;
        if (grant_d) d_rdata <= m_rdata;
        else i_rdata <= m_rdata;
      end
    end
  end
endmodule
